// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Counter width able to hold the values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_mnbit_seq_if.sv
// Start/done handshake and operand/result bus of the sequential multiplier.
interface mult_mnbit_seq_if #(
    parameter int unsigned M = 4,
    parameter int unsigned N = 4
);

    logic             start;
    logic             acc_en;
    logic [M-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [M+N-1:0]   p;
    logic             ovf;

    modport master (
        output start, acc_en, a, b,
        input  busy, done, p, ovf
    );

    modport slave (
        input  start, acc_en, a, b,
        output busy, done, p, ovf
    );

endinterface

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder; the carry is rippled inside one comb block.
module rca_nbit #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic carry;

    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/mult_mnbit_seq.sv
// Sequential MxN unsigned shift-add multiplier, one multiplier bit per clock,
// with optional accumulate into the result register.
module mult_mnbit_seq
    import mult_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    mult_mnbit_seq_if.slave  bus
);

    localparam int unsigned CW = cnt_w(N);
    localparam int unsigned W  = M + N;
    localparam logic [CW-1:0] CntLast = CW'(N - 1);

    state_e         state_q, state_d;
    logic [M-1:0]   mcand_q, mcand_d;
    logic           c_q, c_d;
    logic [M-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   p_q, p_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [M-1:0]   pp_sum;
    logic           pp_co;
    logic [W-1:0]   acc_sum;
    logic           acc_co;
    logic           c_n;
    logic [M-1:0]   hi_n;

    rca_nbit #(.N(M)) u_pp_add (
        .a_i    (hi_q),
        .b_i    (mcand_q),
        .cin_i  (1'b0),
        .sum_o  (pp_sum),
        .cout_o (pp_co)
    );

    rca_nbit #(.N(W)) u_acc_add (
        .a_i    (p_q),
        .b_i    ({hi_q, lo_q}),
        .cin_i  (1'b0),
        .sum_o  (acc_sum),
        .cout_o (acc_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (cnt_q == CntLast) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mcand_d = mcand_q;
        c_d     = c_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        c_n     = c_q;
        hi_n    = hi_q;
        busy_d  = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    c_d     = 1'b0;
                    hi_d    = '0;
                    lo_d    = bus.b;
                    acc_d   = bus.acc_en;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // Conditionally add the multiplicand, then shift {c, hi, lo} right.
                if (lo_q[0]) begin
                    c_n  = pp_co;
                    hi_n = pp_sum;
                end
                c_d   = 1'b0;
                hi_d  = {c_n, hi_n[M-1:1]};
                lo_d  = {hi_n[0], lo_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
            end
            StDone: begin
                p_d    = acc_q ? acc_sum : {hi_q, lo_q};
                ovf_d  = acc_q & acc_co;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            c_q     <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            c_q     <= c_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mult_mnbit_seq.sv
// Bench for mult_mnbit_seq: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_mult_mnbit_seq;

    localparam int unsigned M = 4;
    localparam int unsigned N = 4;
    localparam int unsigned W = M + N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_mnbit_seq_if #(.M(M), .N(N)) bus ();

    mult_mnbit_seq #(.M(M), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dcnt = 0;

    // Model: an accepted operation finishes N+1 edges later with a*b (optionally accumulated).
    logic         m_busy;
    logic         m_done;
    logic         m_acc;
    logic         m_ovf;
    logic [W-1:0] m_p;
    logic [W-1:0] m_prod;
    int           m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_acc  <= 1'b0;
            m_ovf  <= 1'b0;
            m_p    <= '0;
            m_prod <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy <= 1'b1;
                    m_left <= N + 1;
                    m_prod <= W'(bus.a) * W'(bus.b);
                    m_acc  <= bus.acc_en;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_ovf, m_p} <= m_acc ? ({1'b0, m_p} + {1'b0, m_prod}) : {1'b0, m_prod};
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.done === 1'b1) dcnt++;
        check("model_busy", 32'(bus.busy), 32'(m_busy));
        check("model_done", 32'(bus.done), 32'(m_done));
        check("model_p", 32'(bus.p), 32'(m_p));
        check("model_ovf", 32'(bus.ovf), 32'(m_ovf));
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [M-1:0] aa, input logic [N-1:0] bb, input logic acc);
        bus.start  = 1'b1;
        bus.a      = aa;
        bus.b      = bb;
        bus.acc_en = acc;
        next();
        bus.start  = 1'b0;
        bus.a      = M'($urandom);
        bus.b      = N'($urandom);
        bus.acc_en = 1'($urandom);
    endtask

    // Returns at the negedge of the done cycle; lat = edges after the accept edge.
    task automatic wait_done(output int lat, output int bcnt);
        bit found;
        found = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat   = i;
                found = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) bcnt++;
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, bcnt, t1;

    initial begin
        bus.start  = 1'b0;
        bus.acc_en = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_p", 32'(bus.p), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_ovf", 32'(bus.ovf), 32'd0);
        next();

        op(4'd13, 4'd11, 1'b0);
        wait_done(lat, bcnt);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_busy_cycles", 32'(bcnt), 32'd5);
        check("t1_p", 32'(bus.p), 32'd143);
        check("t1_ovf", 32'(bus.ovf), 32'd0);
        next();

        op(4'd15, 4'd15, 1'b0);
        wait_done(lat, bcnt);
        check("t2_p", 32'(bus.p), 32'd225);
        next();
        op(4'd15, 4'd15, 1'b1);
        wait_done(lat, bcnt);
        check("t2_acc_p", 32'(bus.p), 32'd194);
        check("t2_acc_ovf", 32'(bus.ovf), 32'd1);
        next();

        op(4'd9, 4'd0, 1'b0);
        wait_done(lat, bcnt);
        check("t3_b0_p", 32'(bus.p), 32'd0);
        next();
        op(4'd0, 4'd15, 1'b0);
        wait_done(lat, bcnt);
        check("t3_a0_p", 32'(bus.p), 32'd0);
        next();
        op(4'd3, 4'd5, 1'b1);
        wait_done(lat, bcnt);
        check("t3_acc_p", 32'(bus.p), 32'd15);
        check("t3_acc_ovf", 32'(bus.ovf), 32'd0);
        next();

        // Start held with fresh operands through the whole busy period.
        dcnt = 0;
        op(4'd5, 4'd6, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.start  = 1'b1;
            bus.a      = M'($urandom);
            bus.b      = N'($urandom);
            bus.acc_en = 1'($urandom);
            next();
        end
        bus.start = 1'b0;
        repeat (8) next();
        check("t4_done_count", 32'(dcnt), 32'd1);
        check("t4_p", 32'(bus.p), 32'd30);

        // Reset in the third RUN cycle.
        op(4'd9, 4'd9, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        dcnt = 0;
        rst = 1'b1;
        #1;
        check("t5_rst_p", 32'(bus.p), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check("t5_rst_ovf", 32'(bus.ovf), 32'd0);
        repeat (2) next();
        rst = 1'b0;
        repeat (8) next();
        check("t5_no_done", 32'(dcnt), 32'd0);
        op(4'd6, 4'd7, 1'b0);
        wait_done(lat, bcnt);
        check("t5_p", 32'(bus.p), 32'd42);
        next();

        // Back-to-back: second start issued in the done cycle.
        op(4'd2, 4'd3, 1'b0);
        wait_done(lat, bcnt);
        check("t6_first_p", 32'(bus.p), 32'd6);
        t1 = cyc;
        op(4'd7, 4'd8, 1'b1);
        wait_done(lat, bcnt);
        check("t6_second_p", 32'(bus.p), 32'd62);
        check("t6_done_spacing", 32'(cyc - t1), 32'd6);
        next();

        for (int i = 0; i < 800; i++) begin
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.a      = M'($urandom);
            bus.b      = N'($urandom);
            bus.acc_en = 1'($urandom);
            next();
        end
        bus.start = 1'b0;
        repeat (10) next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
